// File: rtl/rx_frame_controller.sv
// UART receive framing FSM: start validation, data shift, optional parity, stop check.
// Frame results and detector re-arm are issued in the clock cycle of the sampling tick.
module rx_frame_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rx_arst_n,
    input  logic                 rx_en,
    input  logic                 rx_rst,
    input  logic                 baud_tick,
    input  logic                 begin_receive,
    input  logic                 rx,
    output logic                 det_rearm,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q, par_d;
    logic                 load_c;
    logic                 ferr_c;
    logic                 perr_c;
    logic                 rearm_c;
    logic                 half_pt;
    logic                 full_pt;

    assign half_pt = baud_tick && (tick_q == HALF_LAST);
    assign full_pt = baud_tick && (tick_q == FULL_LAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        load_c  = 1'b0;
        ferr_c  = 1'b0;
        perr_c  = 1'b0;
        rearm_c = 1'b0;

        if (baud_tick) begin
            tick_d = tick_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (begin_receive) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_pt) begin
                    tick_d = '0;
                    bit_d  = '0;
                    if (!rx) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        rearm_c = 1'b1;
                    end
                end
            end
            DATA: begin
                if (full_pt) begin
                    tick_d  = '0;
                    shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (full_pt) begin
                    tick_d  = '0;
                    par_d   = rx;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (full_pt) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    rearm_c = 1'b1;
                    load_c  = rx;
                    ferr_c  = !rx;
                    perr_c  = HAS_PAR && (^shreg_q ^ par_q ^ ODD_PAR);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear and disable abort any frame in progress without reporting it
        if (rx_rst || !rx_en) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
            rearm_c = 1'b1;
            load_c  = 1'b0;
            ferr_c  = 1'b0;
            perr_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            if (load_c) begin
                data_q <= shreg_q;
            end
        end
    end

    // New word is visible in the same cycle as its rx_valid pulse
    assign rx_data    = load_c ? shreg_q : data_q;
    assign rx_valid   = load_c;
    assign frame_err  = ferr_c;
    assign parity_err = perr_c;
    assign det_rearm  = rearm_c & rx_arst_n;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_controller.sv
// Scoreboard bench: one 8N1 and one 8E1 receiver listen to the same random line.
// Expected results come from the bit-level frame contents of each line frame.
module tb_rx_frame_controller;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rx_arst_n = 1'b0;
    logic rx_en = 1'b1;
    logic rx_rst = 1'b0;
    logic baud_tick = 1'b0;
    logic rx = 1'b1;
    logic [1:0] br;
    logic [1:0] seen_hi;

    logic rearm_n, rearm_p, valid_n, valid_p;
    logic ferr_n, ferr_p, perr_n, perr_p;
    logic busy_n, busy_p;
    logic [7:0] data_n, data_p;
    logic [1:0] rearm, valid, ferr, perr, busy;

    assign rearm = {rearm_p, rearm_n};
    assign valid = {valid_p, valid_n};
    assign ferr  = {ferr_p, ferr_n};
    assign perr  = {perr_p, perr_n};
    assign busy  = {busy_p, busy_n};

    always #5 clk = ~clk;

    rx_frame_controller #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_n (
        .clk(clk), .rx_arst_n(rx_arst_n), .rx_en(rx_en), .rx_rst(rx_rst),
        .baud_tick(baud_tick), .begin_receive(br[0]), .rx(rx),
        .det_rearm(rearm_n), .rx_data(data_n), .rx_valid(valid_n),
        .frame_err(ferr_n), .parity_err(perr_n), .busy(busy_n)
    );

    rx_frame_controller #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_p (
        .clk(clk), .rx_arst_n(rx_arst_n), .rx_en(rx_en), .rx_rst(rx_rst),
        .baud_tick(baud_tick), .begin_receive(br[1]), .rx(rx),
        .det_rearm(rearm_p), .rx_data(data_p), .rx_valid(valid_p),
        .frame_err(ferr_p), .parity_err(perr_p), .busy(busy_p)
    );

    // Edge detector model: needs a high sample, then a low one, until re-armed
    always @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            br      <= 2'b00;
            seen_hi <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rearm[i]) begin
                    br[i]      <= 1'b0;
                    seen_hi[i] <= 1'b0;
                end else if (baud_tick && !br[i]) begin
                    if (rx) seen_hi[i] <= 1'b1;
                    else if (seen_hi[i]) br[i] <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic       ok;
        logic       pe;
        logic [7:0] d;
        int         t;
    } exp_t;

    exp_t q_n[$];
    exp_t q_p[$];
    int n_cmp = 0;
    int n_bad = 0;
    int tick_no = 0;
    int tick_seen = 0;
    int rearm_cnt[2] = '{0, 0};
    logic [7:0] last[2] = '{8'h00, 8'h00};
    logic [1:0] chk_busy = 2'b00;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // Monitor: pops one expectation per reported frame result
    always @(negedge clk) begin
        exp_t e;
        if (baud_tick) tick_seen++;
        for (int i = 0; i < 2; i++) begin
            if (chk_busy[i]) begin
                chk($sformatf("busy_after_frame%0d", i), 32'(busy[i]), 0);
                chk_busy[i] = 1'b0;
            end
            if (rearm[i]) rearm_cnt[i]++;
            if (valid[i] || ferr[i] || perr[i]) begin
                if ((i == 0 && q_n.size() == 0) || (i == 1 && q_p.size() == 0)) begin
                    chk($sformatf("unexpected_out%0d", i),
                        32'({valid[i], ferr[i], perr[i]}), 0);
                end else begin
                    if (i == 0) e = q_n.pop_front();
                    else e = q_p.pop_front();
                    chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(e.ok));
                    chk($sformatf("frame_err%0d", i), 32'(ferr[i]), 32'(!e.ok));
                    chk($sformatf("parity_err%0d", i), 32'(perr[i]), 32'(e.pe));
                    chk($sformatf("rx_data%0d", i),
                        32'(i == 0 ? data_n : data_p), 32'(e.d));
                    chk($sformatf("latency_tick%0d", i), tick_seen, e.t);
                    chk($sformatf("rearm_with_out%0d", i), 32'(rearm[i]), 1);
                    chk_busy[i] = 1'b1;
                end
            end
        end
    end

    task automatic tick1(input logic v);
        @(posedge clk); #1;
        rx = v;
        baud_tick = 1'b1;
        tick_no++;
        @(posedge clk); #1;
        baud_tick = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // b[0] start, b[8:1] data LSB first, b[9], b[10] as seen on the line
    task automatic push_frame(input logic [10:0] b);
        exp_t e;
        int s;
        s = tick_no + 1;
        e.ok = b[9];
        e.pe = 1'b0;
        e.d  = b[9] ? b[8:1] : last[0];
        e.t  = s + 9 * OS + OS / 2;
        if (b[9]) last[0] = b[8:1];
        q_n.push_back(e);
        e.ok = b[10];
        e.pe = ^b[9:1];
        e.d  = b[10] ? b[8:1] : last[1];
        e.t  = s + 10 * OS + OS / 2;
        if (b[10]) last[1] = b[8:1];
        q_p.push_back(e);
    endtask

    task automatic abort(input int kind);
        @(posedge clk); #1;
        if (kind == 1) rx_rst = 1'b1;
        else rx_en = 1'b0;
        @(negedge clk);
        chk("abort_rearm", 32'(rearm), 32'(2'b11));
        @(posedge clk); #1;
        rx_rst = 1'b0;
        rx_en = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
    endtask

    task automatic areset();
        #2;
        rx_arst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_ferr", 32'(ferr), 0);
        chk("arst_perr", 32'(perr), 0);
        chk("arst_rearm", 32'(rearm), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", 32'({data_p, data_n}), 0);
        last[0] = 8'h00;
        last[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rx_arst_n = 1'b1;
    endtask

    task automatic stall();
        repeat (40) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy), 32'(2'b11));
    endtask

    // kind: 0 clean, 1 rx_rst, 2 rx_en low, 3 async reset, 4 tick stall
    task automatic send(input logic [10:0] b, input int kind, input int at);
        logic cut;
        cut = 1'b0;
        if (kind == 0 || kind == 4) push_frame(b);
        for (int t = 0; t < 11 * OS; t++) begin
            tick1(cut ? 1'b1 : b[t / OS]);
            if (t == at) begin
                case (kind)
                    1, 2: begin abort(kind); cut = 1'b1; end
                    3: begin areset(); cut = 1'b1; end
                    4: stall();
                    default: ;
                endcase
            end
        end
        for (int t = 0; t < 2 * OS; t++) tick1(1'b1);
    endtask

    initial begin
        int r0, r1;
        logic [7:0] d;
        logic b9, b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rearm", 32'(rearm), 0);
        chk("reset_data", 32'({data_p, data_n}), 0);
        @(posedge clk); #1;
        rx_arst_n = 1'b1;
        repeat (20) tick1(1'b1);

        send({2'b11, 8'hA5, 1'b0}, 0, 0);
        r0 = rearm_cnt[0];
        r1 = rearm_cnt[1];
        repeat (4) tick1(1'b0);
        repeat (3 * OS) tick1(1'b1);
        chk("glitch_rearm0", rearm_cnt[0], r0 + 1);
        chk("glitch_rearm1", rearm_cnt[1], r1 + 1);
        chk("glitch_busy", 32'(busy), 0);
        send({2'b00, 8'h3C, 1'b0}, 0, 0);
        send({2'b10, 8'h07, 1'b0}, 0, 0);
        send({2'b11, 8'h99, 1'b0}, 1, 60);
        send({2'b11, 8'h5A, 1'b0}, 0, 0);
        send({2'b11, 8'h33, 1'b0}, 2, 100);
        send({2'b11, 8'hC3, 1'b0}, 3, 146);
        send({2'b00, 8'h44, 1'b0}, 0, 0);
        send({2'b11, 8'h81, 1'b0}, 4, 90);
        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom);
            b9  = 1'($urandom);
            b10 = b9 ? 1'b1 : 1'($urandom);
            send({b10, b9, d, 1'b0}, 0, 0);
        end
        repeat (50) @(posedge clk);
        chk("drain_n", q_n.size(), 0);
        chk("drain_p", q_p.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
